// File: rtl/syn_gpu_div_mc.sv
`default_nettype none
// ============================================================================
// Module      : syn_gpu_div_mc
// Description : Iterative radix-4 divider slave for the GPU mulberry bus.
//               MID-tagged requests are queued in order, divided one at a
//               time (signed or unsigned, with divide-by-zero detection)
//               and answered with a MID-tagged {quotient, remainder}.
// Revision    : 1.0 - initial release
// ============================================================================
module syn_gpu_div_mc #(
    parameter int WIDTH      = 16,
    parameter int MID_W      = 4,
    parameter int MID_IDLE   = 0,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk_ir,
    input  logic                 rst_ir,
    input  logic [MID_W-1:0]     div_req_mid,
    input  logic [2*WIDTH-1:0]   div_req_data,
    input  logic                 div_req_signed,
    output logic                 div_busy,
    output logic                 div_drop,
    output logic [MID_W-1:0]     div_rsp_mid,
    output logic [2*WIDTH-1:0]   div_rsp_data,
    output logic                 div_rsp_dz
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int C_ENTRY_W = MID_W + 1 + 2 * WIDTH;
    localparam int C_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int C_CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int C_ITER_W  = $clog2(WIDTH / 2 + 1);
    localparam int C_PW      = WIDTH + 2;

    localparam logic [MID_W-1:0]    C_MID_IDLE  = MID_IDLE[MID_W-1:0];
    localparam logic [C_CNT_W-1:0]  C_FULL_CNT  = C_CNT_W'(FIFO_DEPTH);
    localparam logic [C_ITER_W-1:0] C_ITER_INIT = C_ITER_W'(WIDTH / 2);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_ITER = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_RSP  = 3'd4;

    // ------------------------------------------------------------------
    // Request queue
    // ------------------------------------------------------------------
    logic [C_ENTRY_W-1:0] r_fifo [FIFO_DEPTH];
    logic [C_PTR_W-1:0]   r_wr_ptr;
    logic [C_PTR_W-1:0]   r_rd_ptr;
    logic [C_CNT_W-1:0]   r_count;
    logic                 r_drop;

    logic                 w_req_valid;
    logic                 w_full;
    logic                 w_not_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [C_ENTRY_W-1:0] w_head;

    assign w_req_valid = (div_req_mid != C_MID_IDLE);
    assign w_full      = (r_count == C_FULL_CNT);
    assign w_not_empty = (r_count != '0);
    assign w_push      = w_req_valid && !w_full;
    assign w_head      = r_fifo[r_rd_ptr];

    // Queue storage; contents are meaningless while the count says empty,
    // so the array itself needs no reset.
    always_ff @(posedge clk_ir) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {div_req_mid, div_req_signed, div_req_data};
        end
    end

    // Queue pointers, occupancy and the one-cycle drop indication.
    always_ff @(posedge clk_ir or posedge rst_ir) begin
        if (rst_ir) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_drop   <= 1'b0;
        end else begin
            r_drop <= w_req_valid && w_full;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_W'(1);
                2'b01:   r_count <= r_count - C_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    logic [2:0]          r_state;
    logic [2:0]          w_state_next;
    logic [C_ITER_W-1:0] r_iter;
    logic                w_dz;
    logic                w_rsp_load_dz;
    logic                w_rsp_load_fix;
    logic                w_rsp_clear;
    logic                w_prep;
    logic                w_step;

    // State register.
    always_ff @(posedge clk_ir or posedge rst_ir) begin
        if (rst_ir) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_not_empty) w_state_next = S_LOAD;
            S_LOAD: w_state_next = w_dz ? S_RSP : S_ITER;
            S_ITER: if (r_iter == C_ITER_W'(1)) w_state_next = S_FIX;
            S_FIX:  w_state_next = S_RSP;
            S_RSP:  w_state_next = w_not_empty ? S_LOAD : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Per-state control strobes for the queue and datapath.
    always_comb begin
        w_pop          = 1'b0;
        w_prep         = 1'b0;
        w_step         = 1'b0;
        w_rsp_load_dz  = 1'b0;
        w_rsp_load_fix = 1'b0;
        w_rsp_clear    = 1'b0;
        case (r_state)
            S_IDLE: w_pop = w_not_empty;
            S_LOAD: begin
                w_prep        = 1'b1;
                w_rsp_load_dz = w_dz;
            end
            S_ITER: w_step = 1'b1;
            S_FIX:  w_rsp_load_fix = 1'b1;
            S_RSP: begin
                w_rsp_clear = 1'b1;
                w_pop       = w_not_empty;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic [MID_W-1:0] r_mid;
    logic             r_signed;
    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;
    logic             r_sn;
    logic             r_sd;
    logic [WIDTH-1:0] r_num;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_p;
    logic [C_PW-1:0]  r_d1;
    logic [C_PW-1:0]  r_d2;
    logic [C_PW-1:0]  r_d3;

    logic             w_sn;
    logic             w_sd;
    logic [WIDTH-1:0] w_abs_n;
    logic [WIDTH-1:0] w_abs_d;
    logic [C_PW-1:0]  w_d1;
    logic [C_PW-1:0]  w_d2;

    // Operand sign capture and magnitudes; the most-negative value keeps
    // its bit pattern, which is the correct unsigned magnitude.
    assign w_dz    = (r_divisor == '0);
    assign w_sn    = r_signed && r_dividend[WIDTH-1];
    assign w_sd    = r_signed && r_divisor[WIDTH-1];
    assign w_abs_n = w_sn ? -r_dividend : r_dividend;
    assign w_abs_d = w_sd ? -r_divisor  : r_divisor;
    assign w_d1    = C_PW'(w_abs_d);
    assign w_d2    = C_PW'({w_abs_d, 1'b0});

    logic [C_PW-1:0]  w_p_ext;
    logic [C_PW-1:0]  w_sub;
    logic [1:0]       w_digit;
    logic [WIDTH-1:0] w_p_rem;

    assign w_p_ext = {r_p, r_num[WIDTH-1 -: 2]};

    // Radix-4 digit selection: largest multiple of d not exceeding P'.
    always_comb begin
        w_digit = 2'd0;
        w_sub   = '0;
        if (w_p_ext >= r_d3) begin
            w_digit = 2'd3;
            w_sub   = r_d3;
        end else if (w_p_ext >= r_d2) begin
            w_digit = 2'd2;
            w_sub   = r_d2;
        end else if (w_p_ext >= r_d1) begin
            w_digit = 2'd1;
            w_sub   = r_d1;
        end
    end

    // The remainder is always below d, so it fits in WIDTH bits.
    assign w_p_rem = WIDTH'(w_p_ext - w_sub);

    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    // Truncating-division sign fix-up; the remainder follows the dividend.
    assign w_q_fix = (r_sn ^ r_sd) ? -r_q : r_q;
    assign w_r_fix = r_sn ? -r_p : r_p;

    // Operand latch, precompute and iteration registers.
    always_ff @(posedge clk_ir or posedge rst_ir) begin
        if (rst_ir) begin
            r_mid      <= C_MID_IDLE;
            r_signed   <= 1'b0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_sn       <= 1'b0;
            r_sd       <= 1'b0;
            r_num      <= '0;
            r_q        <= '0;
            r_p        <= '0;
            r_d1       <= '0;
            r_d2       <= '0;
            r_d3       <= '0;
            r_iter     <= '0;
        end else begin
            if (w_pop) begin
                {r_mid, r_signed, r_dividend, r_divisor} <= w_head;
            end
            if (w_prep) begin
                r_sn   <= w_sn;
                r_sd   <= w_sd;
                r_num  <= w_abs_n;
                r_q    <= '0;
                r_p    <= '0;
                r_d1   <= w_d1;
                r_d2   <= w_d2;
                r_d3   <= w_d1 + w_d2;
                r_iter <= C_ITER_INIT;
            end
            if (w_step) begin
                r_p    <= w_p_rem;
                r_q    <= {r_q[WIDTH-3:0], w_digit};
                r_num  <= {r_num[WIDTH-3:0], 2'b00};
                r_iter <= r_iter - C_ITER_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Response registers
    // ------------------------------------------------------------------
    logic [MID_W-1:0]   r_rsp_mid;
    logic [2*WIDTH-1:0] r_rsp_data;
    logic               r_rsp_dz;

    // Response is loaded on the edge into RSP; the tag lasts one cycle
    // while data and dz hold until the next response.
    always_ff @(posedge clk_ir or posedge rst_ir) begin
        if (rst_ir) begin
            r_rsp_mid  <= C_MID_IDLE;
            r_rsp_data <= '0;
            r_rsp_dz   <= 1'b0;
        end else if (w_rsp_load_dz) begin
            r_rsp_mid  <= r_mid;
            r_rsp_data <= {{WIDTH{1'b1}}, r_dividend};
            r_rsp_dz   <= 1'b1;
        end else if (w_rsp_load_fix) begin
            r_rsp_mid  <= r_mid;
            r_rsp_data <= {w_q_fix, w_r_fix};
            r_rsp_dz   <= 1'b0;
        end else if (w_rsp_clear) begin
            r_rsp_mid  <= C_MID_IDLE;
        end
    end

    assign div_busy     = w_full;
    assign div_drop     = r_drop;
    assign div_rsp_mid  = r_rsp_mid;
    assign div_rsp_data = r_rsp_data;
    assign div_rsp_dz   = r_rsp_dz;

endmodule
`default_nettype wire

// File: tb/tb_syn_gpu_div_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_syn_gpu_div_mc
// Description : Directed, table-driven self-checking bench for syn_gpu_div_mc
//               (WIDTH=16, MID_W=4, FIFO_DEPTH=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_syn_gpu_div_mc;

    localparam int W  = 16;
    localparam int MW = 4;

    logic          clk_ir = 1'b0;
    logic          rst_ir;
    logic [MW-1:0] div_req_mid;
    logic [2*W-1:0] div_req_data;
    logic          div_req_signed;
    logic          div_busy;
    logic          div_drop;
    logic [MW-1:0] div_rsp_mid;
    logic [2*W-1:0] div_rsp_data;
    logic          div_rsp_dz;

    syn_gpu_div_mc #(
        .WIDTH      (W),
        .MID_W      (MW),
        .MID_IDLE   (0),
        .FIFO_DEPTH (2)
    ) dut (
        .clk_ir         (clk_ir),
        .rst_ir         (rst_ir),
        .div_req_mid    (div_req_mid),
        .div_req_data   (div_req_data),
        .div_req_signed (div_req_signed),
        .div_busy       (div_busy),
        .div_drop       (div_drop),
        .div_rsp_mid    (div_rsp_mid),
        .div_rsp_data   (div_rsp_data),
        .div_rsp_dz     (div_rsp_dz)
    );

    always #5 clk_ir = ~clk_ir;

    typedef struct {
        logic [MW-1:0] mid;
        logic          sgn;
        logic [W-1:0]  n;
        logic [W-1:0]  d;
        logic [W-1:0]  q;
        logic [W-1:0]  r;
        logic          dz;
    } vec_t;

    vec_t vecs [14];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        div_req_mid    = '0;
        div_req_data   = '0;
        div_req_signed = 1'b0;
    endtask

    // Issue one request with the block idle, check silence until the expected
    // cycle, the response itself, and the tag dropping while data holds.
    task automatic run_vec(input vec_t v, input string nm);
        int lat;
        bit early;
        lat   = v.dz ? 3 : 12;
        early = 1'b0;
        @(negedge clk_ir);
        div_req_mid    = v.mid;
        div_req_signed = v.sgn;
        div_req_data   = {v.n, v.d};
        for (int j = 1; j <= lat + 1; j++) begin
            @(negedge clk_ir);
            idle_inputs();
            if (j < lat && div_rsp_mid !== '0) early = 1'b1;
            if (j == lat) begin
                chk({nm, "_mid"},  64'(div_rsp_mid),  64'(v.mid));
                chk({nm, "_data"}, 64'(div_rsp_data), 64'({v.q, v.r}));
                chk({nm, "_dz"},   64'(div_rsp_dz),   64'(v.dz));
            end
            if (j == lat + 1) begin
                chk({nm, "_mid_clear"}, 64'(div_rsp_mid),  64'(0));
                chk({nm, "_data_hold"}, 64'(div_rsp_data), 64'({v.q, v.r}));
            end
        end
        chk({nm, "_no_early"}, 64'(early), 64'(0));
    endtask

    initial begin
        vecs[0]  = '{4'd3,  1'b0, 16'd100,  16'd7,    16'h000E, 16'h0002, 1'b0};
        vecs[1]  = '{4'd6,  1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0};
        vecs[2]  = '{4'd7,  1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0};
        vecs[3]  = '{4'd8,  1'b1, 16'hFFF9, 16'hFFFE, 16'h0003, 16'hFFFF, 1'b0};
        vecs[4]  = '{4'd5,  1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1};
        vecs[5]  = '{4'd9,  1'b0, 16'd9,    16'd3,    16'h0003, 16'h0000, 1'b0};
        vecs[6]  = '{4'd10, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0};
        vecs[7]  = '{4'd11, 1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0};
        vecs[8]  = '{4'd12, 1'b0, 16'd5,    16'd9,    16'h0000, 16'h0005, 1'b0};
        vecs[9]  = '{4'd13, 1'b1, 16'hFFF9, 16'h0000, 16'hFFFF, 16'hFFF9, 1'b1};
        vecs[10] = '{4'd14, 1'b0, 16'hFFFE, 16'h8001, 16'h0001, 16'h7FFD, 1'b0};
        vecs[11] = '{4'd15, 1'b0, 16'hFFF9, 16'h0002, 16'h7FFC, 16'h0001, 1'b0};
        vecs[12] = '{4'd2,  1'b1, 16'h8000, 16'h0003, 16'hD556, 16'hFFFE, 1'b0};
        vecs[13] = '{4'd1,  1'b0, 16'hC350, 16'h00C8, 16'h00FA, 16'h0000, 1'b0};

        // Reset state
        idle_inputs();
        rst_ir = 1'b1;
        repeat (3) @(negedge clk_ir);
        chk("rst_busy", 64'(div_busy),     64'(0));
        chk("rst_drop", 64'(div_drop),     64'(0));
        chk("rst_mid",  64'(div_rsp_mid),  64'(0));
        chk("rst_data", 64'(div_rsp_data), 64'(0));
        chk("rst_dz",   64'(div_rsp_dz),   64'(0));
        rst_ir = 1'b0;
        @(negedge clk_ir);

        // Directed single-request table
        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Queue full and drop: mids 1..5 back to back, mid 4 re-issued at j=13
        begin
            logic [MW-1:0]  exp_mid;
            logic           exp_busy;
            logic           exp_drop;
            logic [2*W-1:0] exp_data;
            for (int j = 0; j <= 48; j++) begin
                if (j > 0) @(negedge clk_ir);
                case (j)
                    0:  begin div_req_mid = 4'd1; div_req_signed = 1'b0; div_req_data = {16'd100,  16'd7};  end
                    1:  begin div_req_mid = 4'd2; div_req_signed = 1'b0; div_req_data = {16'd200,  16'd9};  end
                    2:  begin div_req_mid = 4'd3; div_req_signed = 1'b0; div_req_data = {16'd1000, 16'd33}; end
                    3:  begin div_req_mid = 4'd4; div_req_signed = 1'b0; div_req_data = {16'd50,   16'd5};  end
                    4:  begin div_req_mid = 4'd5; div_req_signed = 1'b0; div_req_data = {16'd60,   16'd6};  end
                    13: begin div_req_mid = 4'd4; div_req_signed = 1'b0; div_req_data = {16'd42,   16'd5};  end
                    default: idle_inputs();
                endcase
                exp_busy = (j >= 3 && j <= 12) || (j >= 14 && j <= 23);
                exp_drop = (j == 4) || (j == 5);
                exp_mid  = (j == 12) ? 4'd1 : (j == 23) ? 4'd2 :
                           (j == 34) ? 4'd3 : (j == 45) ? 4'd4 : 4'd0;
                chk($sformatf("q_busy_%0d", j), 64'(div_busy),    64'(exp_busy));
                chk($sformatf("q_drop_%0d", j), 64'(div_drop),    64'(exp_drop));
                chk($sformatf("q_mid_%0d", j),  64'(div_rsp_mid), 64'(exp_mid));
                if (exp_mid != 4'd0) begin
                    exp_data = (j == 12) ? {16'h000E, 16'h0002} :
                               (j == 23) ? {16'h0016, 16'h0002} :
                               (j == 34) ? {16'h001E, 16'h000A} :
                                           {16'h0008, 16'h0002};
                    chk($sformatf("q_data_%0d", j), 64'(div_rsp_data), 64'(exp_data));
                end
            end
            idle_inputs();
        end

        // Reset during ITER with a second request queued
        begin
            bit spurious;
            spurious = 1'b0;
            @(negedge clk_ir);
            div_req_mid = 4'd1; div_req_data = {16'd100, 16'd7};
            @(negedge clk_ir);
            div_req_mid = 4'd2; div_req_data = {16'd200, 16'd9};
            @(negedge clk_ir);
            idle_inputs();
            chk("pre_rst_busy", 64'(div_busy), 64'(0));
            repeat (3) @(negedge clk_ir);
            rst_ir = 1'b1;
            @(negedge clk_ir);
            chk("mid_rst_mid",  64'(div_rsp_mid),  64'(0));
            chk("mid_rst_data", 64'(div_rsp_data), 64'(0));
            chk("mid_rst_dz",   64'(div_rsp_dz),   64'(0));
            chk("mid_rst_busy", 64'(div_busy),     64'(0));
            @(negedge clk_ir);
            rst_ir = 1'b0;
            for (int j = 0; j < 25; j++) begin
                @(negedge clk_ir);
                if (div_rsp_mid !== '0 || div_drop !== 1'b0 || div_busy !== 1'b0 ||
                    div_rsp_data !== '0 || div_rsp_dz !== 1'b0)
                    spurious = 1'b1;
            end
            chk("post_rst_quiet", 64'(spurious), 64'(0));
            run_vec(vecs[0], "post_rst");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
